// File: rtl/mod_down_counter_if.sv
// Control and status bundle for mod_down_counter: enable/load inputs in,
// registered count/borrow and combinational zero out.
interface mod_down_counter_if #(
    parameter int X = 4
);
    // Level-sampled, no handshake: en and load are read on every rising clk.
    // borrow is a one-cycle pulse; zero tracks count continuously.
    logic         en;
    logic         load;
    logic [X-1:0] load_val;
    logic [X-1:0] count;
    logic         borrow;
    logic         zero;

    modport master (
        output en,
        output load,
        output load_val,
        input  count,
        input  borrow,
        input  zero
    );

    modport slave (
        input  en,
        input  load,
        input  load_val,
        output count,
        output borrow,
        output zero
    );
endinterface

// File: rtl/mod_down_counter.sv
// Modulo-N down counter with clamped parallel load, borrow pulse and zero flag.
// Define MOD_DOWN_COUNTER_ONESHOT_EN to stop at zero instead of wrapping.
module mod_down_counter #(
    parameter int X = 4,
    parameter int N = 10
) (
    input  logic              clk,
    input  logic              reset,
    mod_down_counter_if.slave bus
);
    localparam logic [X-1:0] MAX = X'(N - 1);

    logic [X-1:0] count_q, count_d;
    logic         borrow_q, borrow_d;

    always_comb begin
        count_d  = count_q;
        borrow_d = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
        end else if (bus.en) begin
            if (count_q == '0) begin
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
                // Parked at zero: the single borrow was already issued on 1 -> 0.
                count_d = '0;
`else
                count_d  = MAX;
                borrow_d = 1'b1;
`endif
            end else begin
                count_d = count_q - X'(1);
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
                borrow_d = (count_q == X'(1));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= MAX;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = (count_q == '0);
endmodule

// File: tb/tb_mod_down_counter.sv
// Directed bench for mod_down_counter: reset, wrap, load/clamp, enable gaps,
// two-stage cascade (or one-shot mode when MOD_DOWN_COUNTER_ONESHOT_EN is set).
module tb_mod_down_counter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mod_down_counter_if #(.X(4)) dut_if ();
    mod_down_counter_if #(.X(4)) u_if ();
    mod_down_counter_if #(.X(4)) t_if ();

    mod_down_counter #(.X(4), .N(10)) u_dut   (.clk(clk), .reset(reset), .bus(dut_if));
    mod_down_counter #(.X(4), .N(10)) u_units (.clk(clk), .reset(reset), .bus(u_if));
    mod_down_counter #(.X(4), .N(6))  u_tens  (.clk(clk), .reset(reset), .bus(t_if));

    assign t_if.en       = u_if.borrow;
    assign t_if.load     = 1'b0;
    assign t_if.load_val = '0;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int pulses;
        int tpulses;
        int steps;
        n_checks = 0;
        n_pass   = 0;
        u_if.en = 1'b0; u_if.load = 1'b0; u_if.load_val = '0;

        // reset dominates load and en
        reset = 1'b0; dut_if.load = 1'b1; dut_if.load_val = 4'd3; dut_if.en = 1'b1;
        tick();
        chk("rst_count", dut_if.count, 9);
        chk("rst_borrow", dut_if.borrow, 0);
        chk("rst_zero", dut_if.zero, 0);
        chk("rst_units", u_if.count, 9);
        chk("rst_tens", t_if.count, 5);

        reset = 1'b1; dut_if.load = 1'b0; dut_if.en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("hold_count%0d", k), dut_if.count, 9);
            chk($sformatf("hold_borrow%0d", k), dut_if.borrow, 0);
        end

`ifndef MOD_DOWN_COUNTER_ONESHOT_EN
        // 30 enabled cycles: three full wraps
        dut_if.en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            int e;
            tick();
            e = (99 - k) % 10;
            chk($sformatf("wrap_count%0d", k), dut_if.count, e);
            chk($sformatf("wrap_zero%0d", k), dut_if.zero, (e == 0) ? 1 : 0);
            chk($sformatf("wrap_borrow%0d", k), dut_if.borrow, (k % 10 == 0) ? 1 : 0);
            if (dut_if.borrow) pulses++;
        end
        chk("wrap_pulses", pulses, 3);
        dut_if.en = 1'b0;
`endif

        // load priority over en, clamp above N-1
        dut_if.load = 1'b1; dut_if.load_val = 4'd5; dut_if.en = 1'b1;
        tick();
        chk("load5", dut_if.count, 5);
        dut_if.load_val = 4'd12;
        tick();
        chk("load12_clamp", dut_if.count, 9);
        chk("load12_borrow", dut_if.borrow, 0);
        dut_if.load_val = 4'd10;
        tick();
        chk("load10_clamp", dut_if.count, 9);
        dut_if.load_val = 4'd0;
        tick();
        chk("load0", dut_if.count, 0);
        chk("load0_zero", dut_if.zero, 1);
        dut_if.load_val = 4'd9;
        tick();
        chk("load9", dut_if.count, 9);

        // count down to 0, then load at 0 with en high
        dut_if.load = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("at0_count", dut_if.count, 0);
        chk("at0_zero", dut_if.zero, 1);
        dut_if.load = 1'b1; dut_if.load_val = 4'd7; dut_if.en = 1'b1;
        tick();
        chk("load7_count", dut_if.count, 7);
        chk("load7_borrow", dut_if.borrow, 0);

`ifndef MOD_DOWN_COUNTER_ONESHOT_EN
        // enable gaps from 2: en 1,0,0,1,1 -> 1,1,1,0,9
        begin
            logic       en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            logic [3:0] cnt_exp[5] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd9};
            logic       brw_exp[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            dut_if.load_val = 4'd2; dut_if.en = 1'b0;
            tick();
            chk("gap_load2", dut_if.count, 2);
            dut_if.load = 1'b0;
            for (int k = 0; k < 5; k++) begin
                dut_if.en = en_pat[k];
                tick();
                chk($sformatf("gap_count%0d", k), dut_if.count, cnt_exp[k]);
                chk($sformatf("gap_borrow%0d", k), dut_if.borrow, brw_exp[k]);
                chk($sformatf("gap_zero%0d", k), dut_if.zero, (cnt_exp[k] == 0) ? 1 : 0);
            end
            dut_if.en = 1'b0;
        end

        // cascade: units borrow enables tens; 61 edges cover one tens wrap
        u_if.en = 1'b1;
        tpulses = 0;
        for (int k = 1; k <= 61; k++) begin
            tick();
            steps = (k - 1) / 10;
            chk($sformatf("cas_units%0d", k), u_if.count, (99 - k) % 10);
            chk($sformatf("cas_tens%0d", k), t_if.count, (35 - steps) % 6);
            chk($sformatf("cas_tborrow%0d", k), t_if.borrow, (k == 61) ? 1 : 0);
            if (t_if.borrow) tpulses++;
        end
        u_if.en = 1'b0;
        chk("cas_tpulses", tpulses, 1);
`else
        // one-shot: load 3, run 8 cycles, single borrow the cycle count shows 0
        begin
            logic [3:0] os_cnt[8] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
            dut_if.load_val = 4'd3; dut_if.en = 1'b1;
            tick();
            chk("os_load3", dut_if.count, 3);
            dut_if.load = 1'b0;
            pulses = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                chk($sformatf("os_count%0d", k), dut_if.count, os_cnt[k]);
                chk($sformatf("os_borrow%0d", k), dut_if.borrow, (k == 2) ? 1 : 0);
                if (dut_if.borrow) pulses++;
            end
            chk("os_pulses", pulses, 1);
            dut_if.load = 1'b1; dut_if.load_val = 4'd2;
            tick();
            chk("os_load2", dut_if.count, 2);
            dut_if.load = 1'b0;
            pulses = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("os2_count%0d", k), dut_if.count, (k < 2) ? 1 - k : 0);
                chk($sformatf("os2_borrow%0d", k), dut_if.borrow, (k == 1) ? 1 : 0);
                if (dut_if.borrow) pulses++;
            end
            chk("os2_pulses", pulses, 1);
            dut_if.load = 1'b1; dut_if.load_val = 4'd0;
            tick();
            dut_if.load = 1'b0;
            tick();
            chk("os_load0_borrow", dut_if.borrow, 0);
            chk("os_load0_count", dut_if.count, 0);
            dut_if.en = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
